// File: rtl/aes_sbox_bram.sv
// aes_sbox_bram: FIPS-197 forward S-box with a one-cycle registered read
module aes_sbox_bram (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] addr,
    output logic [7:0] dout
);
    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Synchronous table read every cycle; reset forces 0x00, which no lookup of 0x00 can produce
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dout <= 8'h00;
        else        dout <= SBOX[addr];
    end
endmodule

// File: tb/tb_aes_sbox_bram.sv
// tb_aes_sbox_bram: directed and algorithmic-reference checks of the S-box lookup
module tb_aes_sbox_bram;
    logic       clk;
    logic       rst_n;
    logic [7:0] addr;
    logic [7:0] dout;
    int tests = 0;
    int fails = 0;
    logic [7:0] sbox_ref [0:255];
    logic       seen [0:255];

    typedef struct {
        logic [7:0] a;
        logic [7:0] e;
    } vec_t;
    vec_t vecs [9];

    aes_sbox_bram dut (.clk(clk), .rst_n(rst_n), .addr(addr), .dout(dout));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_model(logic [7:0] x);
        logic [7:0] inv = 8'h00;
        logic [7:0] r;
        if (x != 8'h00) begin
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        end
        r = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        return r;
    endfunction

    task automatic check(string name, logic [7:0] act, logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int distinct;
        vecs[0] = '{8'h00, 8'h63};
        vecs[1] = '{8'h01, 8'h7c};
        vecs[2] = '{8'h10, 8'hca};
        vecs[3] = '{8'h80, 8'hcd};
        vecs[4] = '{8'hff, 8'h16};
        vecs[5] = '{8'hcf, 8'h8a};
        vecs[6] = '{8'h4f, 8'h84};
        vecs[7] = '{8'h3c, 8'heb};
        vecs[8] = '{8'h09, 8'h01};
        for (int i = 0; i < 256; i++) begin
            sbox_ref[i] = sbox_model(i[7:0]);
            seen[i] = 1'b0;
        end

        rst_n = 1'b0;
        addr  = 8'h53;
        #1;
        check("reset_async_initial", dout, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_hold", dout, 8'h00);
        end
        rst_n = 1'b1;
        #2;
        check("reset_release_no_edge", dout, 8'h00);
        tick();
        check("reset_first_read_53", dout, 8'hed);

        for (int i = 0; i < 9; i++) begin
            addr = vecs[i].a;
            tick();
            check($sformatf("vec_%02h", vecs[i].a), dout, vecs[i].e);
        end

        addr = 8'h00;
        tick();
        check("hold_before_change", dout, 8'h63);
        #3;
        addr = 8'h01;
        #1;
        check("hold_no_comb_path", dout, 8'h63);
        #4;
        check("hold_until_edge", dout, 8'h63);
        tick();
        check("hold_after_edge", dout, 8'h7c);

        for (int i = 0; i < 256; i++) begin
            addr = i[7:0];
            tick();
            check($sformatf("sweep_%02h", i), dout, sbox_ref[i]);
            seen[dout] = 1'b1;
            if (i == 100) begin
                #1;
                rst_n = 1'b0;
                #1;
                check("midsweep_async_reset", dout, 8'h00);
                #1;
                rst_n = 1'b1;
                #1;
                check("midsweep_no_stale", dout, 8'h00);
            end
        end
        distinct = 0;
        for (int i = 0; i < 256; i++) if (seen[i]) distinct++;
        tests++;
        if (distinct != 256) begin
            fails++;
            $display("FAIL sweep_distinct: got %0d expected 256", distinct);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
